// File: rtl/voltage_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voltage_monitor_pkg
// Description : Constants shared by the voltage monitor and fault manager.
// Revision    : 1.0 - initial release
// ============================================================================
package voltage_monitor_pkg;

    localparam int ADC_WIDTH = 12;
    localparam logic [ADC_WIDTH-1:0] OV_THRESHOLD = 12'd3500;
    localparam logic [ADC_WIDTH-1:0] UV_THRESHOLD = 12'd2800;

    localparam logic [1:0] ST_RECOVER = 2'd0;
    localparam logic [1:0] ST_NORMAL  = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    // Fault code bit order is {under, over}
    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;
    localparam logic [1:0] FC_BOTH  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/voltage_fault_manager_consecutive_counter.sv
`default_nettype none
// ============================================================================
// Module      : consecutive_counter
// Description : Counts consecutive high samples; pulses when target is hit.
// Revision    : 1.0 - initial release
// ============================================================================
module consecutive_counter #(
    parameter int WIDTH  = 8,
    parameter int TARGET = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    output logic             reached
);

    localparam logic [WIDTH-1:0] c_ceiling = WIDTH'(TARGET);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    assign w_next  = r_count + 1'b1;
    // The pulse fires on the edge that takes the target-th sample, so the
    // consumer reacts on that same edge.
    assign reached = enable & sample & ~clear & (w_next == target);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (clear || !sample || reached) begin
                r_count <= '0;
            end else if (r_count != c_ceiling) begin
                r_count <= w_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voltage_fault_manager.sv
`default_nettype none
// ============================================================================
// Module      : voltage_fault_manager
// Description : Debounces monitor flags, gates power_enable, retries/lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module voltage_fault_manager
    import voltage_monitor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int RECOVER_CYCLES  = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 over_voltage,
    input  logic                                 under_voltage,
    input  logic                                 within_range,
    input  logic                                 fault_clear,
    output logic                                 power_enable,
    output logic                                 fault_active,
    output logic [1:0]                           fault_code,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
    output logic                                 lockout
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RECOVER_CYCLES) ? DEBOUNCE_CYCLES : RECOVER_CYCLES;
    localparam logic [RW-1:0]        c_max_retries = RW'(MAX_RETRIES);
    localparam logic [CNT_WIDTH-1:0] c_debounce    = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_recover     = CNT_WIDTH'(RECOVER_CYCLES);

    logic [1:0]           r_state;
    logic                 w_sample;
    logic [CNT_WIDTH-1:0] w_target;
    logic                 w_enable;
    logic                 w_clear;
    logic                 w_hit;
    logic                 w_lockout_exit;

    assign w_lockout_exit = (r_state == ST_LOCKOUT) & fault_clear & within_range;

    // In FAULT the counter already tracks within_range, so the sample that
    // moves us back to RECOVER is counted as the first good one.
    always_comb begin
        w_sample = within_range;
        w_target = c_recover;
        if (r_state == ST_NORMAL) begin
            w_sample = over_voltage | under_voltage;
            w_target = c_debounce;
        end
    end

    assign w_enable = (r_state != ST_LOCKOUT) | w_lockout_exit;
    assign w_clear  = w_lockout_exit;

    consecutive_counter #(
        .WIDTH  (CNT_WIDTH),
        .TARGET (CNT_MAX)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_enable),
        .sample  (w_sample),
        .clear   (w_clear),
        .target  (w_target),
        .reached (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RECOVER;
            power_enable <= 1'b0;
            fault_active <= 1'b0;
            fault_code   <= FC_NONE;
            retry_count  <= '0;
            lockout      <= 1'b0;
        end else begin
            case (r_state)
                ST_RECOVER: begin
                    if (w_hit) begin
                        r_state      <= ST_NORMAL;
                        power_enable <= 1'b1;
                    end
                end
                ST_NORMAL: begin
                    // Qualification takes precedence over a same-edge clear.
                    if (w_hit) begin
                        fault_code   <= {under_voltage, over_voltage};
                        power_enable <= 1'b0;
                        fault_active <= 1'b1;
                        if (retry_count < c_max_retries) begin
                            retry_count <= retry_count + 1'b1;
                            r_state     <= ST_FAULT;
                        end else begin
                            lockout <= 1'b1;
                            r_state <= ST_LOCKOUT;
                        end
                    end else if (fault_clear) begin
                        retry_count <= '0;
                        fault_code  <= FC_NONE;
                    end
                end
                ST_FAULT: begin
                    if (within_range) begin
                        r_state      <= ST_RECOVER;
                        fault_active <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_lockout_exit) begin
                        r_state      <= ST_RECOVER;
                        fault_active <= 1'b0;
                        lockout      <= 1'b0;
                        retry_count  <= '0;
                        fault_code   <= FC_NONE;
                    end
                end
                default: begin
                    r_state      <= ST_RECOVER;
                    power_enable <= 1'b0;
                    fault_active <= 1'b0;
                    lockout      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voltage_fault_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_voltage_fault_manager
// Description : Directed self-checking bench for voltage_fault_manager.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voltage_fault_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic       over_voltage;
    logic       under_voltage;
    logic       within_range;
    logic       fault_clear;
    logic       power_enable;
    logic       fault_active;
    logic [1:0] fault_code;
    logic [1:0] retry_count;
    logic       lockout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voltage_fault_manager dut (
        .clk           (clk),
        .reset         (reset),
        .over_voltage  (over_voltage),
        .under_voltage (under_voltage),
        .within_range  (within_range),
        .fault_clear   (fault_clear),
        .power_enable  (power_enable),
        .fault_active  (fault_active),
        .fault_code    (fault_code),
        .retry_count   (retry_count),
        .lockout       (lockout)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic pe, input logic fa,
                           input logic [1:0] fc, input logic [1:0] rc, input logic lo);
        chk({tag, "_pe"}, {7'd0, power_enable}, {7'd0, pe});
        chk({tag, "_fa"}, {7'd0, fault_active}, {7'd0, fa});
        chk({tag, "_fc"}, {6'd0, fault_code},   {6'd0, fc});
        chk({tag, "_rc"}, {6'd0, retry_count},  {6'd0, rc});
        chk({tag, "_lo"}, {7'd0, lockout},      {7'd0, lo});
    endtask

    initial begin
        reset = 1'b1; over_voltage = 1'b0; under_voltage = 1'b0;
        within_range = 1'b0; fault_clear = 1'b0;
        step(2);
        chk_all("reset", 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);

        // Power-up: 16 good samples
        reset = 1'b0; within_range = 1'b1;
        step(15);
        chk("pwrup_15", {7'd0, power_enable}, 8'd0);
        step(1);
        chk_all("pwrup_16", 1'b1, 1'b0, 2'b00, 2'd0, 1'b0);

        // Glitchy over-voltage never reaches 8 in a row
        over_voltage = 1'b1; step(7);
        over_voltage = 1'b0; step(1);
        over_voltage = 1'b1; step(7);
        chk_all("glitch", 1'b1, 1'b0, 2'b00, 2'd0, 1'b0);
        over_voltage = 1'b0; step(1);

        // Under-voltage fault
        under_voltage = 1'b1; step(7);
        chk("uv_7", {7'd0, power_enable}, 8'd1);
        step(1);
        chk_all("uv_8", 1'b0, 1'b1, 2'b10, 2'd1, 1'b0);
        under_voltage = 1'b0;
        step(1);
        chk_all("uv_rec1", 1'b0, 1'b0, 2'b10, 2'd1, 1'b0);
        step(14);
        chk("uv_rec15", {7'd0, power_enable}, 8'd0);
        step(1);
        chk_all("uv_rec16", 1'b1, 1'b0, 2'b10, 2'd1, 1'b0);

        // Software clear in NORMAL
        fault_clear = 1'b1; step(1); fault_clear = 1'b0;
        chk_all("swclr", 1'b1, 1'b0, 2'b00, 2'd0, 1'b0);

        // Three retried over-voltage faults
        for (int i = 0; i < 3; i++) begin
            over_voltage = 1'b1; step(8); over_voltage = 1'b0;
            chk_all("ov_fault", 1'b0, 1'b1, 2'b01, 2'(i + 1), 1'b0);
            step(16);
            chk("ov_recovered", {7'd0, power_enable}, 8'd1);
        end
        // Fourth fault locks out
        over_voltage = 1'b1; step(8); over_voltage = 1'b0;
        chk_all("lock", 1'b0, 1'b1, 2'b01, 2'd3, 1'b1);
        within_range = 1'b0; fault_clear = 1'b1; step(1); fault_clear = 1'b0;
        chk_all("lock_clr_nowr", 1'b0, 1'b1, 2'b01, 2'd3, 1'b1);
        within_range = 1'b1; step(3);
        chk_all("lock_wr_noclr", 1'b0, 1'b1, 2'b01, 2'd3, 1'b1);
        fault_clear = 1'b1; step(1); fault_clear = 1'b0;
        chk_all("lock_exit", 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
        step(15);
        chk("lock_rec15", {7'd0, power_enable}, 8'd0);
        step(1);
        chk("lock_rec16", {7'd0, power_enable}, 8'd1);

        // Both flags together
        over_voltage = 1'b1; under_voltage = 1'b1; step(8);
        over_voltage = 1'b0; under_voltage = 1'b0;
        chk_all("both", 1'b0, 1'b1, 2'b11, 2'd1, 1'b0);

        // Dropout during RECOVER restarts the window
        step(10);
        within_range = 1'b0; step(1);
        chk_all("drop", 1'b0, 1'b0, 2'b11, 2'd1, 1'b0);
        within_range = 1'b1; step(15);
        chk("drop_15", {7'd0, power_enable}, 8'd0);
        step(1);
        chk("drop_16", {7'd0, power_enable}, 8'd1);

        // Reset in mid-debounce
        over_voltage = 1'b1; step(5);
        reset = 1'b1; step(1);
        chk_all("rst_debounce", 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
        reset = 1'b0; over_voltage = 1'b0; step(16);
        chk("rst_rec16", {7'd0, power_enable}, 8'd1);

        // Drive into LOCKOUT, then reset
        for (int i = 0; i < 4; i++) begin
            over_voltage = 1'b1; step(8); over_voltage = 1'b0;
            if (i < 3) step(16);
        end
        chk_all("lock2", 1'b0, 1'b1, 2'b01, 2'd3, 1'b1);
        reset = 1'b1; step(1);
        chk_all("rst_lock", 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
        reset = 1'b0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
